// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-back, write-allocate data cache controller with
// 32-byte (256-bit) lines. Hits complete with zero added latency: load data is
// returned combinationally and store data is written at the next clock edge.
// A miss stalls the CPU and runs an optional write-back of the dirty victim,
// then a line refill. After that the held request hits.
//
// Parameters
//   NUM_SETS      number of lines (power of two, at least 2)
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   p_addr_i      CPU byte address ([4:2] word select, [1:0] ignored)
//   p_data_i      CPU store data
//   p_memread_i   CPU load request
//   p_memwrite_i  CPU store request (takes priority when both are high)
//   p_data_o      load data on a hit, zero otherwise
//   p_stall_o     CPU must hold its request while high
//   mem_addr_o    line-aligned memory address
//   mem_data_o    write-back line data
//   mem_enable_o  memory request
//   mem_write_o   1 = write line, 0 = read line
//   mem_data_i    refill line data, valid with mem_ack_i
//   mem_ack_i     one-cycle completion pulse from memory
//
// Optional feature (macro DCACHE_STATS_EN):
//   hit_count_o   requests that hit while IDLE
//   miss_count_o  misses that leave IDLE for WRITEBACK or ALLOCATE
// -----------------------------------------------------------------------------
module dcache_controller #(
    parameter int NUM_SETS = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  p_addr_i,
    input  logic [31:0]  p_data_i,
    input  logic         p_memread_i,
    input  logic         p_memwrite_i,
    output logic [31:0]  p_data_o,
    output logic         p_stall_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count_o,
    output logic [31:0]  miss_count_o
`endif
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - 5 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITEBACK,
        S_WB_GAP,
        S_ALLOCATE,
        S_REFILL
    } state_t;

    state_t state_q;

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [255:0]        data_mem [NUM_SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       word_sel;
    logic             req;
    logic             hit;
    logic [31:0]      hit_word;
    logic             unused_addr_bits;

    assign idx              = p_addr_i[5 +: IDX_W];
    assign req_tag          = p_addr_i[31 -: TAG_W];
    assign word_sel         = p_addr_i[4:2];
    assign unused_addr_bits = ^p_addr_i[1:0];

    assign req      = p_memread_i | p_memwrite_i;
    // Lookup is only meaningful in IDLE; in every other state the CPU is stalled.
    assign hit      = (state_q == S_IDLE) & req & valid_q[idx] & (tag_mem[idx] == req_tag);
    assign hit_word = data_mem[idx][{word_sel, 5'b0} +: 32];

    assign p_data_o  = hit ? hit_word : 32'h0;
    assign p_stall_o = (state_q == S_IDLE) ? (req & ~hit) : 1'b1;

    // Memory-side outputs are registered and change only on state transitions,
    // so address/write/data stay stable for the whole time enable is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit && p_memwrite_i) begin
                        data_mem[idx][{word_sel, 5'b0} +: 32] <= p_data_i;
                        dirty_q[idx]                          <= 1'b1;
                    end else if (req && !hit) begin
                        mem_enable_o <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= S_WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_mem[idx], idx, 5'b0};
                            mem_data_o  <= data_mem[idx];
                        end else begin
                            state_q     <= S_ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {req_tag, idx, 5'b0};
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        state_q      <= S_WB_GAP;
                    end
                end
                S_WB_GAP: begin
                    // Enable was dropped on the ack; re-raise it for the refill.
                    mem_enable_o <= 1'b1;
                    mem_write_o  <= 1'b0;
                    mem_addr_o   <= {req_tag, idx, 5'b0};
                    state_q      <= S_ALLOCATE;
                end
                S_ALLOCATE: begin
                    if (mem_ack_i) begin
                        mem_enable_o  <= 1'b0;
                        data_mem[idx] <= mem_data_i;
                        tag_mem[idx]  <= req_tag;
                        valid_q[idx]  <= 1'b1;
                        dirty_q[idx]  <= 1'b0;
                        state_q       <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q      <= S_IDLE;
                    mem_enable_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_o  <= 32'h0;
            miss_count_o <= 32'h0;
        end else begin
            if (hit) begin
                hit_count_o <= hit_count_o + 32'd1;
            end
            // A miss in IDLE always leaves for WRITEBACK or ALLOCATE.
            if ((state_q == S_IDLE) && req && !hit) begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule
